// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M iterative divide unit.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remNxt,
  output logic [XLEN-1:0] quoNxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor on entry, so the shifted value fits in XLEN+1 bits and the
  // top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      remNxt = diff[XLEN-1:0];
      quoNxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      remNxt = shifted[XLEN-1:0];
      quoNxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_exec_unit.sv
// Execute-stage RV32M DIV/DIVU/REM/REMU unit; stalls the pipe via OkE while iterating.
module div_exec_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ValidE,
  input  logic [1:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            OkE,
  output logic [XLEN-1:0] ResultE
);

  localparam int CNTW = $clog2(XLEN);
  localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);

  div_state_t      state, stateNxt;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] remR, quoR, divR;
  logic            negQ, negR, remOp;
  logic [XLEN-1:0] stepRem, stepQuo;

  logic            isSigned, aNeg, bNeg, divByZero, overflow;
  logic [XLEN-1:0] aMag, bMag, fastRes, fixRes;

  // Operand decode, only meaningful in IDLE when a new op is presented.
  always_comb begin
    isSigned  = ~FunctE[0];
    aNeg      = isSigned & SrcAE[XLEN-1];
    bNeg      = isSigned & SrcBE[XLEN-1];
    aMag      = aNeg ? -SrcAE : SrcAE;
    bMag      = bNeg ? -SrcBE : SrcBE;
    divByZero = (SrcBE == '0);
    overflow  = isSigned & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
    if (divByZero) fastRes = FunctE[1] ? SrcAE : DIV_ZERO_Q;
    else           fastRes = FunctE[1] ? '0    : DIV_OVF_Q;
    fixRes = remOp ? (negR ? -stepRem : stepRem) : (negQ ? -stepQuo : stepQuo);
  end

  div_step #(.XLEN(XLEN)) uStep (
    .rem     (remR),
    .quo     (quoR),
    .divisor (divR),
    .remNxt  (stepRem),
    .quoNxt  (stepQuo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    OkE      = (state == DONE) | ((state == IDLE) & ~ValidE);
    case (state)
      IDLE:    if (ValidE) stateNxt = (divByZero | overflow) ? DONE : RUN;
      RUN:     if (cnt == LAST) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (KillE) stateNxt = IDLE;
  end

  // ResultE is only written on the edge into DONE, so it holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      remR    <= '0;
      quoR    <= '0;
      divR    <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      remOp   <= 1'b0;
      ResultE <= '0;
    end else if (!KillE) begin
      if (state == IDLE && ValidE) begin
        cnt   <= '0;
        remR  <= '0;
        quoR  <= aMag;
        divR  <= bMag;
        negQ  <= aNeg ^ bNeg;
        negR  <= aNeg;
        remOp <= FunctE[1];
        if (divByZero | overflow) ResultE <= fastRes;
      end else if (state == RUN) begin
        cnt  <= cnt + 1'b1;
        remR <= stepRem;
        quoR <= stepQuo;
        if (cnt == LAST) ResultE <= fixRes;
      end
    end
  end

endmodule
